// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall-cycle counter for performance debug.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          id_regdst,
  input  logic          id_alusrc,
  input  logic          id_memtoreg,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_branch,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_func,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic          ex_regdst,
  output logic          ex_alusrc,
  output logic          ex_memtoreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_branch,
  output logic [1:0]    ex_aluop,
  output logic [5:0]    ex_func,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          regdst;
    logic          alusrc;
    logic          memtoreg;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          branch;
    logic [1:0]    aluop;
    logic [5:0]    func;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
  } idex_t;

  idex_t         id_w;
  idex_t         ex_q, ex_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          uses_rt;
  logic          rt_hit;
  logic          lu;

  assign id_w = {id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite,
                 id_memread, id_memwrite, id_branch, id_aluop, id_func,
                 id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4};

  // rt is a true source only for stores, branches and R-type ops
  assign uses_rt = id_memwrite | id_branch | (id_aluop == 2'b10);
  assign rt_hit  = (ex_q.rt == id_rs) | (uses_rt & (ex_q.rt == id_rt));
  assign lu      = ex_q.valid & ex_q.memread & (ex_q.rt != 5'd0) & rt_hit & id_valid;
  assign stall   = (lu | hold) & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (lu) begin
      ex_d = '0;
    end else begin
      ex_d = id_w;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regdst   = ex_q.regdst;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_branch   = ex_q.branch;
  assign ex_aluop    = ex_q.aluop;
  assign ex_func     = ex_q.func;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rdata1   = ex_q.rdata1;
  assign ex_rdata2   = ex_q.rdata2;
  assign ex_imm      = ex_q.imm;
  assign ex_pc4      = ex_q.pc4;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        regdst;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } instr_t;

  typedef struct {
    int     cyc;
    instr_t ex;
    logic   st;
    int     cnt;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   flush = 1'b0;
  logic   hold = 1'b0;
  instr_t cur = '0;
  instr_t act;
  exp_t   sb[$];
  int     total = 0;
  int     passed = 0;
  int     cyc = 0;

  logic        ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic        ex_memread, ex_memwrite, ex_branch;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_func;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic        stall;
  logic [15:0] stall_cnt;

  logic        s_valid, s_regdst, s_alusrc, s_memtoreg, s_regwrite;
  logic        s_memread, s_memwrite, s_branch;
  logic [1:0]  s_aluop;
  logic [5:0]  s_func;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
  logic        s_stall;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(cur.valid), .id_regdst(cur.regdst), .id_alusrc(cur.alusrc),
    .id_memtoreg(cur.memtoreg), .id_regwrite(cur.regwrite), .id_memread(cur.memread),
    .id_memwrite(cur.memwrite), .id_branch(cur.branch), .id_aluop(cur.aluop),
    .id_func(cur.func), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .id_rdata1(cur.rdata1), .id_rdata2(cur.rdata2), .id_imm(cur.imm), .id_pc4(cur.pc4),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
    .ex_func(ex_func), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation
  id_ex_stage #(.DW(32), .CW(4)) dut_sat (
    .clk(clk), .reset(reset),
    .id_valid(cur.valid), .id_regdst(cur.regdst), .id_alusrc(cur.alusrc),
    .id_memtoreg(cur.memtoreg), .id_regwrite(cur.regwrite), .id_memread(cur.memread),
    .id_memwrite(cur.memwrite), .id_branch(cur.branch), .id_aluop(cur.aluop),
    .id_func(cur.func), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .id_rdata1(cur.rdata1), .id_rdata2(cur.rdata2), .id_imm(cur.imm), .id_pc4(cur.pc4),
    .flush(flush), .hold(hold),
    .ex_valid(s_valid), .ex_regdst(s_regdst), .ex_alusrc(s_alusrc),
    .ex_memtoreg(s_memtoreg), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_branch(s_branch), .ex_aluop(s_aluop),
    .ex_func(s_func), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
    .stall(s_stall), .stall_cnt(s_cnt)
  );

  assign act = {ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
                ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_func,
                ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4};

  function automatic instr_t mk(input logic [7:0] ctl, input logic [1:0] aluop,
                                input logic [5:0] func, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [31:0] pc4);
    return {ctl, aluop, func, rs, rt, rd, d1, d2, imm, pc4};
  endfunction

  task automatic check(input string nm, input int c, input logic [191:0] got,
                       input logic [191:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL c%0d %s got=%0h want=%0h", c, nm, got, want);
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_fields", e.cyc, 192'(act), 192'(e.ex));
        check("stall", e.cyc, 192'(stall), 192'(e.st));
        check("stall_cnt", e.cyc, 192'(stall_cnt), 192'(e.cnt));
        check("stall_cnt4", e.cyc, 192'(s_cnt), 192'((e.cnt > 15) ? 15 : e.cnt));
      end
    end
  end

  task automatic step(input instr_t i, input logic f, input logic h, input logic r,
                      input instr_t e, input logic s, input int c);
    exp_t x;
    @(posedge clk);
    #1;
    cur = i; flush = f; hold = h; reset = r;
    x.cyc = cyc; x.ex = e; x.st = s; x.cnt = c;
    sb.push_back(x);
    cyc++;
  endtask

  function automatic instr_t rnd();
    instr_t t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t;
  endfunction

  initial begin
    instr_t z, rt_i, lw8, add8, lw0, addi0, lw9, addi9, sw9;
    //         valid,regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch
    z     = '0;
    rt_i  = mk(8'b1100_1000, 2'b10, 6'h20, 5'd1, 5'd2, 5'd3,  32'h5,    32'h7,  32'h20,   32'h100);
    lw8   = mk(8'b1011_1100, 2'b00, 6'h04, 5'd4, 5'd8, 5'd0,  32'h1000, 32'hAA, 32'h4,    32'h104);
    add8  = mk(8'b1100_1000, 2'b10, 6'h20, 5'd8, 5'd9, 5'd10, 32'h11,   32'h22, 32'h5020, 32'h108);
    lw0   = mk(8'b1011_1100, 2'b00, 6'h08, 5'd3, 5'd0, 5'd0,  32'h200,  32'h0,  32'h8,    32'h10C);
    addi0 = mk(8'b1010_1000, 2'b00, 6'h05, 5'd0, 5'd5, 5'd0,  32'h0,    32'h33, 32'h5,    32'h110);
    lw9   = mk(8'b1011_1100, 2'b00, 6'h0C, 5'd2, 5'd9, 5'd0,  32'h300,  32'h44, 32'hC,    32'h114);
    addi9 = mk(8'b1010_1000, 2'b00, 6'h01, 5'd3, 5'd9, 5'd0,  32'h55,   32'h66, 32'h1,    32'h118);
    sw9   = mk(8'b1010_0010, 2'b00, 6'h10, 5'd2, 5'd9, 5'd0,  32'h400,  32'h77, 32'h10,   32'h11C);

    //   id     flush hold reset  exp_ex stall cnt
    step(rnd(), 0, 0, 1, z,     0, 0);
    step(rnd(), 0, 0, 1, z,     0, 0);
    step(rt_i,  0, 0, 0, z,     0, 0);
    step(lw8,   0, 0, 0, rt_i,  0, 0);
    step(add8,  0, 0, 0, lw8,   1, 0);
    step(add8,  0, 0, 0, z,     0, 1);
    step(lw0,   0, 0, 0, add8,  0, 1);
    step(addi0, 0, 0, 0, lw0,   0, 1);
    step(lw9,   0, 0, 0, addi0, 0, 1);
    step(addi9, 0, 0, 0, lw9,   0, 1);
    step(lw9,   0, 0, 0, addi9, 0, 1);
    step(sw9,   0, 0, 0, lw9,   1, 1);
    step(sw9,   0, 0, 0, z,     0, 2);
    step(lw8,   0, 0, 0, sw9,   0, 2);
    step(add8,  1, 0, 0, lw8,   0, 2);
    step(rt_i,  0, 0, 0, z,     0, 2);
    step(add8,  0, 0, 0, rt_i,  0, 2);
    step(rt_i,  0, 1, 0, add8,  1, 2);
    step(rt_i,  0, 1, 0, add8,  1, 3);
    step(rt_i,  0, 1, 0, add8,  1, 4);
    step(rt_i,  0, 0, 0, add8,  0, 5);
    step(lw8,   0, 0, 0, rt_i,  0, 5);
    step(add8,  0, 1, 0, lw8,   1, 5);
    step(add8,  0, 0, 0, lw8,   1, 6);
    step(add8,  0, 0, 0, z,     0, 7);
    for (int k = 0; k < 20; k++) step(add8, 0, 1, 0, add8, 1, 7 + k);
    step(lw8,   0, 0, 0, add8,  0, 27);
    step(add8,  0, 0, 1, lw8,   1, 27);
    step(add8,  0, 0, 0, z,     0, 0);
    step(rt_i,  0, 0, 0, add8,  0, 0);

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and load-use hazard unit between instruction decode and execute in the five-stage pipelined CPU. It captures the decoded control word (including the 2-bit `aluop` and 6-bit `func` consumed by the ALU control unit), the operands and the register indices. It inserts bubbles on load-use hazards and branch flushes, and drives the stall request back to the IF and ID stages. It also keeps a saturating count of stall cycles for performance debug.

## Interface
Parameters:
- `DW`, 32, datapath width for operands, immediate and PC+4.
- `CW`, 16, width of the stall-cycle counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `id_valid` input 1: ID holds a real instruction.
- `id_regdst`, `id_alusrc`, `id_memtoreg`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_branch` input 1 each: decoded control bits.
- `id_aluop` input 2: ALU op class (00 add, 01 sub/branch, 10 R-type).
- `id_func` input 6: instruction bits [5:0].
- `id_rs`, `id_rt`, `id_rd` input 5 each: register indices.
- `id_rdata1`, `id_rdata2`, `id_imm`, `id_pc4` input DW each: operands, sign-extended immediate, PC+4.
- `flush` input 1: branch taken in a later stage; squash ID.
- `hold` input 1: downstream stall; freeze this register.
- `ex_*` output: registered copies of every `id_*` input above, same widths (`ex_valid` … `ex_pc4`).
- `stall` output 1: combinational; IF/ID must hold PC and IF/ID register.
- `stall_cnt` output CW: saturating count of cycles in which `stall`=1.

## Operation
- Load-use hazard: `lu` = `ex_valid` & `ex_memread` & (`ex_rt`≠0) & (`ex_rt`==`id_rs` | (`uses_rt` & `ex_rt`==`id_rt`)) & `id_valid`.
  - `uses_rt` = `id_memwrite` | `id_branch` | (`id_aluop`==2'b10).
- `stall` = (`lu` | `hold`) & ~`flush`.
- Register update priority per edge:
  1. `reset`: all `ex_*` cleared to 0, `stall_cnt`=0.
  2. `flush`: bubble loaded.
  3. `hold`: all `ex_*` keep their value.
  4. `lu`: bubble loaded.
  5. Otherwise: all `id_*` captured into `ex_*`.
- Bubble: every `ex_*` field set to 0, i.e. `ex_valid`=0, all control bits 0, `ex_aluop`=00, `ex_func`=0, data fields 0. A bubble never writes the register file or memory.
- `stall_cnt` increments by 1 on each edge where `stall`=1 and `reset`=0. It holds at all-ones, with no wrap.
- `ex_rt`==0 never raises a hazard (register $0).
- A bubble already in EX (`ex_valid`=0) never causes a hazard, so a load-use stall lasts exactly one cycle.
- `flush` together with `lu`: the flush wins. A bubble is loaded, `stall`=0, and the count does not increment.
- `hold` together with `lu`: the register holds, `stall`=1. The hazard is re-evaluated next cycle against unchanged EX contents.

## Timing
- Latency: ID inputs appear on `ex_*` one clock after capture.
- `stall` is valid in the same cycle as the ID inputs and EX state, with no register in its path.
- Reset values: every `ex_*` output 0, `stall_cnt` 0. `stall` evaluates to 0 because `ex_valid`=0.
- `reset` asserted mid-stall clears state at the next edge. The stall request drops combinationally once `ex_valid`=0.
- No handshake beyond `stall`/`hold`. Upstream must present identical `id_*` while `stall`=1.

## Test plan
- Reset: assert `reset` 2 cycles with random `id_*` → all `ex_*`=0, `stall_cnt`=0, `stall`=0.
- Pass-through: `id_valid`=1, `id_aluop`=10, `id_func`=6'h20, `id_rdata1`=32'h5, `id_rdata2`=32'h7, no hazard → next cycle `ex_aluop`=10, `ex_func`=6'h20, `ex_rdata1`=5, `ex_rdata2`=7.
- Load-use:
  - Setup: lw with `rt`=8 in EX, then add with `rs`=8 in ID.
  - Required: `stall`=1 for exactly one cycle, then a bubble in EX (`ex_valid`=0, `ex_regwrite`=0), then add captured. `stall_cnt`=1.
- No-hazard cases → `stall`=0:
  - lw `rt`=0 in EX, ID `rs`=0.
  - lw `rt`=9 in EX, ID I-type add with `id_rt`=9 and `aluop`=00.
- Flush priority: a load-use condition with `flush`=1 in the same cycle → `stall`=0, bubble loaded, `stall_cnt` unchanged.
- Hold and saturation:
  - `hold`=1 for 3 cycles → `ex_*` frozen, `stall_cnt`+=3.
  - Preload `stall_cnt` near max via `CW`=4 and 20 held cycles → counter stays at 4'hF.
